// File: rtl/fir_band_scheduler_pkg.sv
// fir_sched_pkg: shared types, constants and the output scaling function
// for the time-multiplexed band filter scheduler.
//
// Contents:
//   state_t    - scheduler FSM states (IDLE, MAC, DRAIN, OUT)
//   N_DEF, NUM_BANDS_DEF, DATA_W, COEF_W, COEF_FRAC, PROD_W, ACC_W
//   sat_shift  - accumulator -> DATA_W result (arithmetic shift + saturate)
//
// Optional feature macro: FIR_SCHED_ROUNDING_EN
//   defined   : round half up (add 2^(COEF_FRAC-1)) before the shift
//   undefined : plain truncating arithmetic shift
package fir_sched_pkg;

    localparam int N_DEF         = 31;
    localparam int NUM_BANDS_DEF = 10;
    localparam int DATA_W        = 24;
    localparam int COEF_W        = 12;
    localparam int COEF_FRAC     = 11;
    localparam int PROD_W        = DATA_W + COEF_W;
    localparam int ACC_W         = DATA_W + COEF_W + $clog2(N_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic logic signed [DATA_W-1:0] sat_shift(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] biased;
        logic signed [ACC_W-1:0] shifted;
        logic [ACC_W-DATA_W:0]   top;
`ifdef FIR_SCHED_ROUNDING_EN
        biased = acc + ACC_W'(1 << (COEF_FRAC - 1));
`else
        biased = acc;
`endif
        shifted = biased >>> COEF_FRAC;
        // In range when every bit above the result MSB matches the sign.
        top = shifted[ACC_W-1:DATA_W-1];
        if (top == '0 || top == '1) begin
            return shifted[DATA_W-1:0];
        end else if (shifted[ACC_W-1]) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/fir_band_scheduler_if.sv
// fir_band_scheduler_if: sample input, coefficient ROM and band result bus
// of the band scheduler.
//
// Signals:
//   sample_valid, audio_in          - input sample strobe and data
//   coef_addr, coef_data            - synchronous ROM address / read data
//   band_valid, band_idx, band_data - per-band result stream
// Modports:
//   slave  - the scheduler side
//   master - the sample source / ROM / result sink side
interface fir_band_scheduler_if #(
    parameter int ADDR_W = 9,
    parameter int IDX_W  = 4
);
    logic                                      sample_valid;
    logic signed [fir_sched_pkg::DATA_W-1:0]   audio_in;
    logic        [ADDR_W-1:0]                  coef_addr;
    logic signed [fir_sched_pkg::COEF_W-1:0]   coef_data;
    logic                                      band_valid;
    logic        [IDX_W-1:0]                   band_idx;
    logic signed [fir_sched_pkg::DATA_W-1:0]   band_data;

    modport slave (
        input  sample_valid, audio_in, coef_data,
        output coef_addr, band_valid, band_idx, band_data
    );

    modport master (
        output sample_valid, audio_in, coef_data,
        input  coef_addr, band_valid, band_idx, band_data
    );
endinterface

// File: rtl/fir_band_scheduler_delay_line.sv
// fir_delay_line: N-entry circular sample buffer.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears buffer, pointer)
//   wr_en       - write wr_data at the current write pointer
//   wr_data     - sample to store
//   advance     - move the write pointer to the next slot (wraps N-1 -> 0)
//   rd_off      - age of the sample to read (0 = newest)
//   rd_data     - combinational read of entry (wr_ptr - rd_off) mod N
module fir_delay_line
    import fir_sched_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int PTR_W = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     advance,
    input  logic [PTR_W-1:0]         rd_off,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [N];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
            end
            if (advance) begin
                wr_ptr <= (wr_ptr == PTR_W'(N - 1)) ? '0 : wr_ptr + 1'b1;
            end
        end
    end

    // Modulo-N subtraction without a divider.
    always_comb begin
        rd_idx = (wr_ptr >= rd_off) ? (wr_ptr - rd_off)
                                    : (wr_ptr + PTR_W'(N) - rd_off);
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fir_band_scheduler.sv
// fir_band_scheduler: one shared multiply-accumulate unit evaluates every
// band filter in turn for each accepted sample, reading coefficients from an
// external synchronous ROM (address = band*N + tap, 1-cycle read latency).
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   enable     - low aborts the current sample and ignores new samples
//   bus        - fir_band_scheduler_if.slave (sample in, ROM, band results)
//   busy       - high while a sample is being processed (incl. one tail cycle)
//   overrun    - sticky: a sample arrived while busy and was dropped
//
// Optional feature macro: FIR_SCHED_ROUNDING_EN (see fir_sched_pkg::sat_shift)
module fir_band_scheduler
    import fir_sched_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int NUM_BANDS = NUM_BANDS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    fir_band_scheduler_if.slave  bus,
    output logic                 busy,
    output logic                 overrun
);

    localparam int ADDR_W = $clog2(N * NUM_BANDS);
    localparam int IDX_W  = $clog2(NUM_BANDS);
    localparam int TAP_W  = $clog2(N);

    state_t                   state;
    state_t                   state_next;
    logic [TAP_W-1:0]         tap;
    logic [IDX_W-1:0]         band;
    logic [ADDR_W-1:0]        addr_mac;
    logic [ADDR_W-1:0]        addr_hold;
    logic signed [DATA_W-1:0] rd_data;
    logic signed [DATA_W-1:0] x_p1;
    logic                     vld_p1;
    logic signed [PROD_W-1:0] prod_p1;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     tail;
    logic                     accept;
    logic                     advance;
    logic                     in_mac;
    logic                     last_tap;
    logic                     last_band;

    assign last_tap  = (tap == TAP_W'(N - 1));
    assign last_band = (band == IDX_W'(NUM_BANDS - 1));
    assign addr_mac  = ADDR_W'(band) * ADDR_W'(N) + ADDR_W'(tap);

    fir_delay_line #(.N(N)) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (bus.audio_in),
        .advance (advance),
        .rd_off  (tap),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = MAC;
                MAC:     if (last_tap) state_next = DRAIN;
                DRAIN:   state_next = OUT;
                OUT:     state_next = last_band ? IDLE : MAC;
                default: state_next = IDLE;
            endcase
        end
    end

    // busy covers the cycle after the final OUT too, so a sample arriving
    // there is counted as an overrun rather than accepted.
    always_comb begin
        in_mac        = (state == MAC);
        busy          = (state != IDLE) || tail;
        accept        = enable && bus.sample_valid && !busy;
        advance       = enable && (state == OUT) && last_band;
        bus.coef_addr = in_mac ? addr_mac : addr_hold;
    end

    // Stage p1: registered delay sample meets the ROM word addressed last cycle.
    assign prod_p1 = PROD_W'(x_p1) * PROD_W'(bus.coef_data);
    assign acc_sum = acc + ACC_W'(prod_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap            <= '0;
            band           <= '0;
            addr_hold      <= '0;
            x_p1           <= '0;
            vld_p1         <= 1'b0;
            acc            <= '0;
            tail           <= 1'b0;
            overrun        <= 1'b0;
            bus.band_valid <= 1'b0;
            bus.band_idx   <= '0;
            bus.band_data  <= '0;
        end else begin
            bus.band_valid <= 1'b0;
            tail           <= advance;
            vld_p1         <= enable && in_mac;
            if (enable && bus.sample_valid && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        tap  <= '0;
                        band <= '0;
                        acc  <= '0;
                    end
                end
                MAC: begin
                    x_p1      <= rd_data;
                    addr_hold <= addr_mac;
                    tap       <= last_tap ? '0 : tap + 1'b1;
                    // Tap 0 has no product in flight yet.
                    if (vld_p1) begin
                        acc <= acc_sum;
                    end
                end
                DRAIN: begin
                    acc <= acc_sum;
                    // Result is registered here so band_valid is seen in OUT.
                    if (enable) begin
                        bus.band_valid <= 1'b1;
                        bus.band_idx   <= band;
                        bus.band_data  <= sat_shift(acc_sum);
                    end
                end
                OUT: begin
                    if (!last_band) begin
                        band <= band + 1'b1;
                        acc  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
